// File: rtl/calc_pkg.sv
// Shared definitions for the calculator stage sequencer: stage width and encodings.
package calc_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    CALC_STAGE_NUM1 = 3'd0,
    CALC_STAGE_NUM2 = 3'd1,
    CALC_STAGE_OP   = 3'd2,
    CALC_STAGE_CALC = 3'd3,
    CALC_STAGE_ANS  = 3'd4
  } calc_stage_e;

endpackage

// File: rtl/calc_stage_sequencer_if.sv
// Button, calculation-handshake and display/latch-enable signals of the stage sequencer.
interface calc_stage_sequencer_if;
  import calc_pkg::*;

  logic               btn_next;
  logic               btn_prev;
  logic               btn_clear;
  logic               calc_done;
  logic               calc_start;
  logic               calc_abort;
  logic               store_num1;
  logic               store_num2;
  logic               store_op;
  logic               display_sw;
  logic               display_op;
  logic               display_answer;
  logic [STAGE_W-1:0] stage;
  logic               timeout_err;

  modport slave (
    input  btn_next, btn_prev, btn_clear, calc_done,
    output calc_start, calc_abort, store_num1, store_num2, store_op,
           display_sw, display_op, display_answer, stage, timeout_err
  );

  modport master (
    output btn_next, btn_prev, btn_clear, calc_done,
    input  calc_start, calc_abort, store_num1, store_num2, store_op,
           display_sw, display_op, display_answer, stage, timeout_err
  );

endinterface

// File: rtl/calc_button_debounce.sv
// Two-flop synchroniser plus debounce for one raw button; emits one 1-cycle pulse per
// accepted press and re-arms only after the button has been stably released.
module calc_button_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic [19:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours (the synchroniser chain depends on it).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      // cnt measures how long sync2 has disagreed with the accepted level
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
        cnt   <= '0;
        level <= sync2;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/calc_stage_sequencer.sv
// Calculator stage sequencer: NUM1 -> NUM2 -> OP -> CALC -> ANS driven by debounced buttons.
// Optional CALC watchdog enabled by defining CALC_SEQ_TIMEOUT_EN.
module calc_stage_sequencer
  import calc_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd100_000_000
) (
  input logic                    clk,
  input logic                    rst,
  calc_stage_sequencer_if.slave  bus
);

  if (DEBOUNCE_CYCLES == 20'd0 || TIMEOUT_CYCLES < 32'd2) begin : g_cfg_check
    $error("calc_stage_sequencer: DEBOUNCE_CYCLES must be >0 and TIMEOUT_CYCLES >= 2");
  end

  logic next_p, prev_p, clear_p;

  calc_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst(rst), .btn(bus.btn_next), .pulse(next_p));
  calc_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(clk), .rst(rst), .btn(bus.btn_prev), .pulse(prev_p));
  calc_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .btn(bus.btn_clear), .pulse(clear_p));

  calc_stage_e state_q, state_d;
  logic        start_q, abort_q, abort_d;
  logic        step_fwd, step_back;

  // Simultaneous next and prev cancel each other; clear overrides both.
  assign step_fwd  = next_p & ~prev_p & ~clear_p;
  assign step_back = prev_p & ~next_p & ~clear_p;

`ifdef CALC_SEQ_TIMEOUT_EN
  logic [31:0] tcnt_q;
  logic        tmo_hit, tmo_d, terr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= (state_q == CALC_STAGE_CALC) ? tcnt_q + 32'd1 : 32'd0;
  end

  assign tmo_hit = (state_q == CALC_STAGE_CALC) && (tcnt_q == TIMEOUT_CYCLES - 32'd1);
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
    tmo_d   = 1'b0;
`endif
    case (state_q)
      CALC_STAGE_NUM1: if (step_fwd) state_d = CALC_STAGE_NUM2;
      CALC_STAGE_NUM2: begin
        if (step_fwd)       state_d = CALC_STAGE_OP;
        else if (step_back) state_d = CALC_STAGE_NUM1;
      end
      CALC_STAGE_OP: begin
        if (step_fwd)       state_d = CALC_STAGE_CALC;
        else if (step_back) state_d = CALC_STAGE_NUM2;
      end
      CALC_STAGE_CALC: begin
        if (clear_p) begin
          abort_d = 1'b1;
        end else if (bus.calc_done) begin
          state_d = CALC_STAGE_ANS;
`ifdef CALC_SEQ_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_d = CALC_STAGE_ANS;
          abort_d = 1'b1;
          tmo_d   = 1'b1;
`endif
        end
      end
      CALC_STAGE_ANS: begin
        if (step_fwd)       state_d = CALC_STAGE_NUM1;
        else if (step_back) state_d = CALC_STAGE_OP;
      end
      default: state_d = CALC_STAGE_NUM1;
    endcase
    if (clear_p) state_d = CALC_STAGE_NUM1;
  end

  // calc_abort is registered: reset clears it, so reset during CALC never pulses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CALC_STAGE_NUM1;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == CALC_STAGE_CALC) && (state_q != CALC_STAGE_CALC);
      abort_q <= abort_d;
    end
  end

`ifdef CALC_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          terr_q <= 1'b0;
    else if (tmo_d)                   terr_q <= 1'b1;
    else if (state_d != CALC_STAGE_ANS) terr_q <= 1'b0;
  end
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.calc_start     = start_q;
  assign bus.calc_abort     = abort_q;
  assign bus.store_num1     = (state_q == CALC_STAGE_NUM1);
  assign bus.store_num2     = (state_q == CALC_STAGE_NUM2);
  assign bus.store_op       = (state_q == CALC_STAGE_OP);
  assign bus.display_sw     = (state_q == CALC_STAGE_NUM1) || (state_q == CALC_STAGE_NUM2);
  assign bus.display_op     = (state_q == CALC_STAGE_OP);
  assign bus.display_answer = (state_q == CALC_STAGE_ANS);
  assign bus.stage          = state_q;

endmodule

// File: tb/tb_calc_stage_sequencer.sv
// Bench for calc_stage_sequencer: directed scenarios plus random button/done sequences
// checked against a stage-level model. Honours CALC_SEQ_TIMEOUT_EN like the design.
module tb_calc_stage_sequencer;

  localparam logic [19:0] DEB = 20'd4;
  localparam logic [31:0] TMO = 32'd16;
  localparam int          REL = 8;  // low cycles after release: sync + debounce re-arm

  localparam int A_NEXT = 0, A_PREV = 1, A_BOTH = 2, A_CLEAR = 3, A_DONE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_stage_sequencer_if bus ();

  calc_stage_sequencer #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int errors  = 0;
  int start_cnt = 0, abort_cnt = 0, stage_chg = 0, ans_seen = 0;
  logic [2:0] last_stage = 3'd0;

  always @(negedge clk) begin
    if (bus.calc_start === 1'b1) start_cnt <= start_cnt + 1;
    if (bus.calc_abort === 1'b1) abort_cnt <= abort_cnt + 1;
    if (bus.stage !== last_stage) stage_chg <= stage_chg + 1;
    if (bus.stage === 3'd4) ans_seen <= ans_seen + 1;
    last_stage <= bus.stage;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Reference: next stage after one accepted event, from the stage rules.
  function automatic int model_next(input int s, input int act);
    if (act == A_CLEAR) return 0;
    if (act == A_DONE)  return (s == 3) ? 4 : s;
    if (s == 3 || act == A_BOTH) return s;
    if (act == A_NEXT) return (s + 1) % 5;
    if (s == 0) return 0;
    return (s == 4) ? 2 : s - 1;
  endfunction

  function automatic logic [5:0] model_dec(input int s);
    // {store_num1, store_num2, store_op, display_sw, display_op, display_answer}
    return {s == 0, s == 1, s == 2, s <= 1, s == 2, s == 4};
  endfunction

  task automatic press(input logic n, input logic p, input logic c, input int hold,
                       input int rel);
    @(posedge clk); #1;
    bus.btn_next = n; bus.btn_prev = p; bus.btn_clear = c;
    repeat (hold) @(posedge clk);
    #1;
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0; bus.btn_clear = 1'b0;
    repeat (rel) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 bus.calc_done = 1'b1;
    @(posedge clk); #1 bus.calc_done = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0; bus.btn_clear = 1'b0; bus.calc_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic walk_to_calc();
    press(1'b1, 1'b0, 1'b0, 6, REL);
    press(1'b1, 1'b0, 1'b0, 6, REL);
    press(1'b1, 1'b0, 1'b0, 6, REL);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.stage, model_dec(0)} !== {3'd0, 6'b100100}) begin
      errors++; $display("FAIL reset_state: got stage=%0d dec=%b, want stage=0 dec=100100",
                         bus.stage, {bus.store_num1, bus.store_num2, bus.store_op,
                         bus.display_sw, bus.display_op, bus.display_answer});
    end
    vectors++;
    if ({bus.calc_start, bus.calc_abort, bus.timeout_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got start/abort/terr=%b, want 000",
                         {bus.calc_start, bus.calc_abort, bus.timeout_err});
    end
  endtask

  task automatic test_debounce();
    int chg0;
    do_reset();
    press(1'b1, 1'b0, 1'b0, 3, REL);
    vectors++;
    if (bus.stage !== 3'd0) begin
      errors++; $display("FAIL short_press: got stage=%0d, want 0", bus.stage);
    end
    chg0 = stage_chg;
    press(1'b1, 1'b0, 1'b0, 6, REL);
    vectors++;
    if (bus.stage !== 3'd1 || bus.store_num2 !== 1'b1) begin
      errors++; $display("FAIL long_press: got stage=%0d store_num2=%b, want 1/1",
                         bus.stage, bus.store_num2);
    end
    vectors++;
    if (stage_chg - chg0 !== 1) begin
      errors++; $display("FAIL one_transition: got %0d stage changes, want 1", stage_chg - chg0);
    end
  endtask

  task automatic test_calc_flow();
    int st0;
    do_reset();
    st0 = start_cnt;
    walk_to_calc();
    vectors++;
    if (bus.stage !== 3'd3 || start_cnt - st0 !== 1) begin
      errors++; $display("FAIL calc_entry: got stage=%0d starts=%0d, want 3/1",
                         bus.stage, start_cnt - st0);
    end
    repeat (2) @(posedge clk);  // calc_done arrives about 10 cycles into CALC
    pulse_done();
    vectors++;
    if (bus.stage !== 3'd4 || bus.display_answer !== 1'b1 || bus.timeout_err !== 1'b0) begin
      errors++; $display("FAIL calc_done: got stage=%0d disp_ans=%b terr=%b, want 4/1/0",
                         bus.stage, bus.display_answer, bus.timeout_err);
    end
    press(1'b1, 1'b0, 1'b0, 6, REL);
    vectors++;
    if (bus.stage !== 3'd0) begin
      errors++; $display("FAIL ans_next: got stage=%0d, want 0", bus.stage);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    press(1'b1, 1'b0, 1'b0, 6, REL);
    press(1'b1, 1'b0, 1'b0, 6, REL);
    press(1'b1, 1'b1, 1'b0, 6, REL);
    vectors++;
    if (bus.stage !== 3'd2) begin
      errors++; $display("FAIL next_prev_both: got stage=%0d, want 2", bus.stage);
    end
    press(1'b0, 1'b1, 1'b0, 6, REL);
    vectors++;
    if (bus.stage !== 3'd1) begin
      errors++; $display("FAIL op_prev: got stage=%0d, want 1", bus.stage);
    end
  endtask

  task automatic test_clear_done();
    int ab0, ans0;
    do_reset();
    press(1'b1, 1'b0, 1'b0, 6, REL);
    press(1'b1, 1'b0, 1'b0, 6, REL);
    press(1'b1, 1'b0, 1'b0, 6, 0);
    ab0 = abort_cnt; ans0 = ans_seen;
    // clear pulse is accepted 2 sync + DEB cycles after the raw edge; align calc_done to it
    @(posedge clk); #1 bus.btn_clear = 1'b1;
    repeat (2 + int'(DEB)) @(posedge clk);
    #1 bus.calc_done = 1'b1;
    @(posedge clk); #1 bus.calc_done = 1'b0; bus.btn_clear = 1'b0;
    repeat (REL) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if (bus.stage !== 3'd0 || abort_cnt - ab0 !== 1 || ans_seen !== ans0) begin
      errors++; $display("FAIL clear_done: got stage=%0d aborts=%0d ans_cycles=%0d, want 0/1/0",
                         bus.stage, abort_cnt - ab0, ans_seen - ans0);
    end
  endtask

  task automatic test_timeout();
    int ab0, chg0;
    do_reset();
    ab0 = abort_cnt;
    walk_to_calc();
`ifdef CALC_SEQ_TIMEOUT_EN
    vectors++;
    if (bus.stage !== 3'd3 || bus.timeout_err !== 1'b0) begin
      errors++; $display("FAIL tmo_pre: got stage=%0d terr=%b, want 3/0", bus.stage, bus.timeout_err);
    end
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if (bus.stage !== 3'd4 || bus.timeout_err !== 1'b1 || abort_cnt - ab0 !== 1) begin
      errors++; $display("FAIL tmo_fire: got stage=%0d terr=%b aborts=%0d, want 4/1/1",
                         bus.stage, bus.timeout_err, abort_cnt - ab0);
    end
    press(1'b0, 1'b1, 1'b0, 6, REL);
    vectors++;
    if (bus.stage !== 3'd2 || bus.timeout_err !== 1'b0) begin
      errors++; $display("FAIL tmo_leave: got stage=%0d terr=%b, want 2/0", bus.stage, bus.timeout_err);
    end
`else
    chg0 = stage_chg;
    repeat (100) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if (bus.stage !== 3'd3 || stage_chg !== chg0 || bus.timeout_err !== 1'b0 ||
        abort_cnt !== ab0) begin
      errors++; $display("FAIL calc_wait: got stage=%0d changes=%0d terr=%b aborts=%0d, want 3/0/0/0",
                         bus.stage, stage_chg - chg0, bus.timeout_err, abort_cnt - ab0);
    end
`endif
  endtask

  task automatic test_async_reset();
    int ab0;
    do_reset();
    walk_to_calc();
    ab0 = abort_cnt;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.stage, bus.store_num1, bus.store_num2, bus.store_op, bus.display_answer,
         bus.calc_start, bus.calc_abort, bus.timeout_err} !== {3'd0, 7'b1000000}) begin
      errors++; $display("FAIL async_reset: got stage=%0d n1/n2/op/ans=%b start/abort/terr=%b, want 0/1000/000",
                         bus.stage, {bus.store_num1, bus.store_num2, bus.store_op, bus.display_answer},
                         {bus.calc_start, bus.calc_abort, bus.timeout_err});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if (abort_cnt !== ab0) begin
      errors++; $display("FAIL reset_no_abort: got %0d aborts, want 0", abort_cnt - ab0);
    end
  endtask

  task automatic test_random();
    int ms, act, exp, hold, st0, ab0;
    do_reset();
    ms = 0;
    for (int i = 0; i < 40; i++) begin
`ifdef CALC_SEQ_TIMEOUT_EN
      act  = (ms == 3) ? A_DONE : int'($urandom_range(0, 4));
      hold = 6;
`else
      act  = int'($urandom_range(0, 4));
      hold = int'($urandom_range(6, 12));
`endif
      st0 = start_cnt; ab0 = abort_cnt;
      case (act)
        A_NEXT:  press(1'b1, 1'b0, 1'b0, hold, REL);
        A_PREV:  press(1'b0, 1'b1, 1'b0, hold, REL);
        A_BOTH:  press(1'b1, 1'b1, 1'b0, hold, REL);
        A_CLEAR: press(1'b0, 1'b0, 1'b1, hold, REL);
        default: pulse_done();
      endcase
      exp = model_next(ms, act);
      vectors++;
      if (int'(bus.stage) !== exp ||
          {bus.store_num1, bus.store_num2, bus.store_op, bus.display_sw, bus.display_op,
           bus.display_answer} !== model_dec(exp)) begin
        errors++; $display("FAIL rand_stage[%0d]: act=%0d from %0d got stage=%0d, want %0d",
                           i, act, ms, bus.stage, exp);
      end
      vectors++;
      if (start_cnt - st0 !== int'(exp == 3 && ms != 3) ||
          abort_cnt - ab0 !== int'(ms == 3 && act == A_CLEAR) || bus.timeout_err !== 1'b0) begin
        errors++; $display("FAIL rand_pulses[%0d]: got starts=%0d aborts=%0d terr=%b, want %0d/%0d/0",
                           i, start_cnt - st0, abort_cnt - ab0, bus.timeout_err,
                           int'(exp == 3 && ms != 3), int'(ms == 3 && act == A_CLEAR));
      end
      ms = exp;
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_calc_flow();
    test_same_cycle();
    test_clear_done();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/calc_stage_sequencer.md
CALC_STAGE_SEQUENCER -- requirements
Module: calc_stage_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20'd1_000_000, meaning consecutive stable cycles required to accept a button press.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'd100_000_000, meaning maximum cycles spent in CALC before forced exit.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports SHALL be clk and rst.
REQ-004 SHALL have the following ports:
- clk  input  1  system clock, all state updates on its rising edge.
- rst  input  1  asynchronous active-high reset.
- btn_next  input  1  raw advance-stage button.
- btn_prev  input  1  raw back-stage button.
- btn_clear  input  1  raw clear button.
- calc_done  input  1  one-cycle pulse from the iterative calculation unit: result valid.
- calc_start  output  1  one-cycle pulse that launches a calculation.
- calc_abort  output  1  one-cycle pulse that cancels a calculation in flight.
- store_num1  output  1  latch enable for operand 1.
- store_num2  output  1  latch enable for operand 2.
- store_op  output  1  latch enable for the opcode.
- display_sw  output  1  display selects the switches.
- display_op  output  1  display selects the opcode.
- display_answer  output  1  display selects the answer.
- stage  output  3  current state encoding.
- timeout_err  output  1  the calculation timed out.

Function
REQ-005 Each button SHALL be synchronised through 2 flops and debounced: a press is accepted when the input is stable high for DEBOUNCE_CYCLES cycles; this yields exactly one 1-cycle pulse per press; the button must be stable low for DEBOUNCE_CYCLES cycles before it re-arms.
REQ-006 States SHALL be NUM1=0, NUM2=1, OP=2, CALC=3, ANS=4; encodings 5-7 SHALL return to NUM1 on the next cycle.
REQ-007 The next pulse SHALL drive these transitions: NUM1->NUM2, NUM2->OP, OP->CALC, ANS->NUM1; next is ignored in CALC.
REQ-008 The prev pulse SHALL drive these transitions: NUM2->NUM1, OP->NUM2, ANS->OP; prev is ignored in NUM1 and CALC.
REQ-009 Next and prev pulses in the same cycle SHALL both be ignored.
REQ-010 A clear pulse SHALL move any state to NUM1 and SHALL take priority over next and prev.
REQ-011 A clear pulse in CALC SHALL also assert calc_abort for exactly 1 cycle.
REQ-012 calc_start SHALL pulse for exactly 1 cycle, in the first cycle spent in CALC.
REQ-013 In CALC, calc_done SHALL move the state to ANS on the next edge; calc_done in any other state SHALL be ignored.
REQ-014 calc_done and clear in the same cycle SHALL resolve to clear, with calc_abort asserted.
REQ-015 The outputs SHALL be Moore outputs decoded from registered state:
- store_num1 = NUM1; store_num2 = NUM2; store_op = OP.
- display_sw = NUM1 or NUM2; display_op = OP; display_answer = ANS.
- stage = state.
REQ-016 Every state transition SHALL take effect on the clock edge after the pulse; the latency from press acceptance to the new outputs is 1 cycle.

Reset
REQ-017 Asserting rst SHALL immediately force:
- state NUM1, so store_num1=1 and all other enables 0;
- calc_start=0, calc_abort=0, timeout_err=0;
- all debounce and timeout counters to 0.
REQ-018 Reset asserted during CALC SHALL NOT pulse calc_abort, because the calculation unit shares rst.

Configuration
REQ-019 With CALC_SEQ_TIMEOUT_EN defined:
- a counter SHALL clear on entry to CALC and increment every cycle in CALC;
- when it reaches TIMEOUT_CYCLES-1 without calc_done, the block SHALL go to ANS, pulse calc_abort for 1 cycle and set timeout_err;
- timeout_err SHALL clear when ANS is left.
REQ-020 Without CALC_SEQ_TIMEOUT_EN, timeout_err SHALL be tied 0, no counter SHALL exist, and CALC SHALL wait indefinitely for calc_done or clear.

Structure
REQ-021 The shared package calc_pkg SHALL hold the state encodings (CALC_STAGE_NUM1..ANS) and the 3-bit stage type width.
REQ-022 One sub-module, calc_button_debounce, SHALL implement synchroniser, debounce and pulse for one button and SHALL be instantiated three times.

Verification (bench: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-023 Reset, then btn_next high for 3 cycles -> state stays NUM1; btn_next high for 6 cycles -> exactly one transition to NUM2, store_num2=1.
REQ-024 Walk NUM1->NUM2->OP->CALC -> calc_start high for exactly 1 cycle; calc_done pulse after 10 cycles -> stage=4, display_answer=1; next -> stage=0.
REQ-025 In OP, accepted next and prev pulses in the same cycle -> stage stays 2; prev alone -> stage=1.
REQ-026 In CALC, clear and calc_done in the same cycle -> stage=0, calc_abort=1 for 1 cycle, never stage=4.
REQ-027 With CALC_SEQ_TIMEOUT_EN: no calc_done for 16 cycles in CALC -> stage=4, timeout_err=1, calc_abort pulsed; prev -> stage=2, timeout_err=0. Without the macro: stage stays 3 for 100 cycles.
REQ-028 Assert rst asynchronously mid-CALC -> outputs take reset values without waiting for a clk edge, and calc_abort stays 0.
